// File: rtl/fp_adder_arbiter.sv
// Round-robin front end that shares a single stb/ack floating-point adder between
// PORTS requesters, with a watchdog that resets the adder if a result never arrives.
module fp_adder_arbiter #(
    parameter int PORTS      = 4,
    parameter int CELL_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                          in_clk,
    input  logic                          in_reset,
    input  logic [PORTS-1:0]              in_req,
    input  logic [PORTS*CELL_WIDTH-1:0]   in_a,
    input  logic [PORTS*CELL_WIDTH-1:0]   in_b,
    input  logic [PORTS-1:0]              in_ack,
    output logic [PORTS-1:0]              out_gnt,
    output logic [PORTS-1:0]              out_done,
    output logic                          out_err,
    output logic [CELL_WIDTH-1:0]         out_z,
    output logic [CELL_WIDTH-1:0]         out_add_a,
    output logic [CELL_WIDTH-1:0]         out_add_b,
    output logic                          out_add_a_stb,
    output logic                          out_add_b_stb,
    output logic                          out_add_z_ack,
    output logic                          out_add_rst,
    input  logic                          in_add_a_ack,
    input  logic                          in_add_b_ack,
    input  logic                          in_add_z_stb,
    input  logic [CELL_WIDTH-1:0]         in_add_z
);

    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_Z, RECOVER, DELIVER} state_t;

    state_t                  state;
    logic [IW-1:0]           last;
    logic [IW-1:0]           cur;
    logic [IW-1:0]           pick;
    logic [IW-1:0]           idx_l;
    logic                    found;
    int                      idx;
    logic [CW-1:0]           cnt;
    logic [PORTS-1:0]        cur_onehot;
    logic [CELL_WIDTH-1:0]   lane_a;
    logic [CELL_WIDTH-1:0]   lane_b;

    // Descending scan so the candidate nearest to last+1 is the one left standing.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        idx_l = '0;
        for (int k = PORTS; k >= 1; k--) begin
            idx   = (int'(last) + k) % PORTS;
            idx_l = IW'(idx);
            if (in_req[idx_l]) begin
                pick  = idx_l;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        lane_a     = in_a[pick*CELL_WIDTH +: CELL_WIDTH];
        lane_b     = in_b[pick*CELL_WIDTH +: CELL_WIDTH];
        cur_onehot = PORTS'(1) << cur;
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state         <= IDLE;
            last          <= IW'(PORTS - 1);
            cur           <= '0;
            cnt           <= '0;
            out_gnt       <= '0;
            out_done      <= '0;
            out_err       <= 1'b0;
            out_z         <= '0;
            out_add_a     <= '0;
            out_add_b     <= '0;
            out_add_a_stb <= 1'b0;
            out_add_b_stb <= 1'b0;
            out_add_z_ack <= 1'b0;
            out_add_rst   <= 1'b1;
        end else begin
            out_gnt       <= '0;
            out_add_z_ack <= 1'b0;
            out_add_rst   <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        out_add_a     <= lane_a;
                        out_add_b     <= lane_b;
                        out_gnt       <= PORTS'(1) << pick;
                        last          <= pick;
                        cur           <= pick;
                        out_add_a_stb <= 1'b1;
                        out_add_b_stb <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (in_add_a_ack) out_add_a_stb <= 1'b0;
                    if (in_add_b_ack) out_add_b_stb <= 1'b0;
                    // Operand acks are independent; leave only once both strobes are retired.
                    if ((!out_add_a_stb || in_add_a_ack) && (!out_add_b_stb || in_add_b_ack)) begin
                        cnt   <= '0;
                        state <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (in_add_z_stb) begin
                        out_z         <= in_add_z;
                        out_add_z_ack <= 1'b1;
                        out_err       <= 1'b0;
                        out_done      <= cur_onehot;
                        state         <= DELIVER;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state <= RECOVER;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RECOVER: begin
                    out_add_rst <= 1'b1;
                    out_z       <= '0;
                    out_err     <= 1'b1;
                    out_done    <= cur_onehot;
                    state       <= DELIVER;
                end
                DELIVER: begin
                    if (in_ack[cur]) begin
                        out_done <= '0;
                        out_z    <= '0;
                        out_err  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
